bcd_xs3_sequencer: RTL and testbench

BCD_XS3_SEQUENCER -- requirements
Module: bcd_xs3_sequencer

---
 rtl/bcd_xs3_sequencer.sv | 116 +++++++++++
 tb/tb_bcd_xs3_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_xs3_sequencer.sv
// Packed BCD to Excess-3 converter: one shared 4-bit digit converter walks the
// captured word one digit per clock, then holds the result until it is consumed.
//
// state | meaning
// IDLE  | waiting for a word; start_ready high
// CONV  | converting captured digit r_idx, one per clock
// DONE  | result valid; waiting for out_ready
module bcd_xs3_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   xs3_out,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  err,
  output logic                  busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [4*DIGITS-1:0]   r_word;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_xs3;
  logic [DIGITS-1:0]     r_mask;
  logic [3:0]            w_digit;
  logic [3:0]            w_conv;
  logic                  w_bad;
  logic                  w_accept;
  logic                  w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    start_ready = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_next = S_CONV;
      end
      S_CONV: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = start_valid && start_ready;
  assign w_last   = (r_idx == LAST_IDX);

  // Single shared converter fed by the digit currently indexed.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) w_digit = r_word[4*i +: 4];
    end
  end

  assign w_bad  = (w_digit > 4'd9);
  assign w_conv = w_bad ? 4'b1111 : (w_digit + 4'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
      r_xs3  <= '0;
      r_mask <= '0;
    end else if (w_accept) begin
      r_word <= bcd_in;
      r_idx  <= '0;
      r_mask <= '0;
    end else if (r_state == S_CONV) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_idx == IW'(i)) begin
          r_xs3[4*i +: 4] <= w_conv;
          r_mask[i]       <= w_bad;
        end
      end
      // Index parks on the last digit rather than wrapping.
      if (!w_last) r_idx <= r_idx + IW'(1);
    end
  end

  assign xs3_out  = r_xs3;
  assign err_mask = r_mask;
  assign err      = |r_mask;

endmodule

// File: tb/tb_bcd_xs3_sequencer.sv
// Bench for bcd_xs3_sequencer (DIGITS=4): directed corner cases plus random
// words checked against a digit-wise arithmetic reference.
module tb_bcd_xs3_sequencer;

  localparam int DIGITS = 4;

  logic                clk;
  logic                rst_n;
  logic                start_valid;
  logic                start_ready;
  logic [4*DIGITS-1:0] bcd_in;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] xs3_out;
  logic [DIGITS-1:0]   err_mask;
  logic                err;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_xs3_sequencer #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .bcd_in      (bcd_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .xs3_out     (xs3_out),
    .err_mask    (err_mask),
    .err         (err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: each digit d becomes d+3 if legal, else 0xF with its error bit set.
  task automatic model(input logic [15:0] w, output logic [15:0] x, output logic [3:0] m);
    int d;
    x = '0;
    m = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((w >> (4*i)) & 16'hF);
      if (d > 9) begin
        x = x | (16'hF << (4*i));
        m[i] = 1'b1;
      end else begin
        x = x | (16'((d + 3) & 15) << (4*i));
      end
    end
  endtask

  task automatic run_word(input logic [15:0] w, input int hold, input bit flood);
    logic [15:0] exp_x;
    logic [3:0]  exp_m;
    int e;
    model(w, exp_x, exp_m);
    e = 0;
    while (!start_ready && e < 50) begin
      @(posedge clk); #1; e++;
    end
    chk("ready_before_accept", start_ready, 1);
    start_valid = 1'b1;
    bcd_in      = w;
    out_ready   = (hold == 0);
    @(posedge clk); #1;
    if (flood) bcd_in = 16'h5555;
    else begin
      start_valid = 1'b0;
      bcd_in      = 16'($urandom);
    end
    e = 1;
    while (!out_valid && e < 20) begin
      chk("busy_in_conv", busy, 1);
      chk("no_ready_in_conv", start_ready, 0);
      @(posedge clk); #1; e++;
    end
    chk("latency", e, DIGITS + 1);
    for (int c = 0; c < hold; c++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_xs3", xs3_out, exp_x);
      chk("hold_mask", err_mask, exp_m);
      chk("hold_err", err, |exp_m);
      chk("hold_no_ready", start_ready, 0);
      @(posedge clk); #1;
    end
    chk("done_valid", out_valid, 1);
    chk("done_xs3", xs3_out, exp_x);
    chk("done_mask", err_mask, exp_m);
    chk("done_err", err, |exp_m);
    out_ready = 1'b1;
    if (flood) start_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", start_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_xs3_kept", xs3_out, exp_x);
  endtask

  initial begin
    logic [15:0] w;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    bcd_in      = '0;
    out_ready   = 1'b0;
    #1;
    chk("rst_ready", start_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xs3", xs3_out, 0);
    chk("rst_mask", err_mask, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_word(16'h1234, 0, 0);
    chk("dir_1234", xs3_out, 16'h4567);
    run_word(16'h9090, 0, 0);
    chk("dir_9090", xs3_out, 16'hC3C3);
    run_word(16'h12A4, 0, 0);
    chk("dir_12A4", xs3_out, 16'h45F7);
    chk("dir_12A4_mask", err_mask, 4'b0010);
    chk("dir_12A4_err", err, 1);
    run_word(16'h0000, 3, 0);
    chk("dir_0000", xs3_out, 16'h3333);
    run_word(16'h0876, 0, 1);
    chk("dir_0876", xs3_out, 16'h3BA9);
    run_word(16'h5555, 0, 0);
    chk("dir_5555", xs3_out, 16'h8888);

    // Reset in the third conversion cycle.
    start_valid = 1'b1;
    bcd_in      = 16'h1234;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_xs3", xs3_out, 0);
    chk("mid_rst_ready", start_ready, 1);
    chk("mid_rst_mask", err_mask, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    run_word(16'h0001, 0, 0);
    chk("dir_0001", xs3_out, 16'h3334);

    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      if (n % 2 == 0) begin
        for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run_word(w, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
